// File: rtl/mmu_pkg.sv
// mmu_pkg: FSM states, alignment mask and fault-cause codes shared by mem_arbiter and future trap logic
package mmu_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  localparam logic [1:0] ALIGN_MASK = 2'b11;
  typedef enum logic [2:0] {FC_NONE, FC_RDWR, FC_ALIGN, FC_LIMIT, FC_WRAP} fault_t;
  function automatic fault_t fault_cause(input logic rdwr, input logic [1:0] lsb, input logic over, input logic wrap);
    return rdwr ? FC_RDWR : |(lsb & ALIGN_MASK) ? FC_ALIGN : over ? FC_LIMIT : wrap ? FC_WRAP : FC_NONE;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first requester at or after ptr (wrapping), one-hot and binary forms
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      idx = req[j] ? j : idx;
    end
    grant = |req ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbitration of NCH client channels onto one memory port,
// with per-channel base/limit translation, alignment checks and wait/segv handshake
module mem_arbiter
  import mmu_pkg::*;
#(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NCH-1:0]    rd,
  input  logic [NCH-1:0]    wd,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*DW-1:0] wdata,
  input  logic [NCH*AW-1:0] seg_base,
  input  logic [NCH*AW-1:0] seg_limit,
  output logic [NCH*DW-1:0] rdata,
  output logic [NCH-1:0]    wait_o,
  output logic [NCH-1:0]    segv,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic              mem_ack,
  input  logic [DW-1:0]     mem_rdata
);
  localparam int IW = $clog2(NCH);
  state_t         state;
  logic [IW-1:0]  rr, g, gi;
  logic [NCH-1:0] req, grant, g_oh, done;
  logic           segv_flag;
  logic [AW-1:0]  a, b, l;
  logic [AW:0]    sum;
  fault_t         cause;
  assign req = rd | wd;
  rr_arbiter #(.N(NCH)) u_rr (.req(req), .ptr(rr), .grant(grant), .idx(gi));
  assign a = addr[gi*AW +: AW];
  assign b = seg_base[gi*AW +: AW];
  assign l = seg_limit[gi*AW +: AW];
  assign sum = {1'b0, b} + {1'b0, a};
  assign cause = fault_cause(rd[gi] & wd[gi], a[1:0], a >= l, sum[AW]);
  assign done = state == RESP ? g_oh : '0;
  assign wait_o = req & ~done;
  assign segv = segv_flag ? done : '0;
  assign mem_req = state == ISSUE;
  // faults skip ISSUE entirely so the memory port never sees a bad access
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      rr <= '0;
      g <= '0;
      g_oh <= '0;
      segv_flag <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      rdata <= '0;
    end else if (state == IDLE && |req) begin
      g <= gi;
      g_oh <= grant;
      segv_flag <= cause != FC_NONE;
      if (cause != FC_NONE) begin
        rdata[gi*DW +: DW] <= '0;
        state <= RESP;
      end else begin
        mem_addr <= sum[AW-1:0];
        mem_we <= wd[gi];
        mem_wdata <= wdata[gi*DW +: DW];
        state <= ISSUE;
      end
    end else if (state == ISSUE && mem_ack) begin
      rdata[g*DW +: DW] <= mem_we ? '0 : mem_rdata;
      state <= RESP;
    end else if (state == RESP) begin
      rr <= g == IW'(NCH - 1) ? '0 : g + 1'b1;
      state <= IDLE;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench; drivers push expected responses, a negedge monitor pops and compares
module tb_mem_arbiter;
  localparam int NCH = 2, AW = 32, DW = 32;
  localparam logic [DW-1:0] SCRAMBLE = 32'hA5A5_0F0F;
  logic clk = 0, reset_n = 0;
  logic [NCH-1:0] rd = '0, wd = '0, wait_o, segv;
  logic [NCH*AW-1:0] addr = '0, seg_base = '0, seg_limit = '0;
  logic [NCH*DW-1:0] wdata = '0, rdata;
  logic mem_req, mem_we, mem_ack = 0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  int passed = 0, total = 0, cyc = 0, ack_dly = 0, ack_cnt = 0, req_cyc = 0;
  bit rand_ack = 0, mon_en = 1, stable = 1, prev_req = 0;
  logic [AW+DW:0] prev_bus = '0;
  typedef struct {logic segv; logic [DW-1:0] rdata; logic [AW-1:0] phys; logic we; logic [DW-1:0] wdata;} exp_t;
  exp_t exp_q[NCH][$];
  int others[NCH];
  int done_ch[$], done_cyc[$];
  logic hs_seen = 0, hs_we = 0;
  logic [AW-1:0] hs_addr = '0;
  logic [DW-1:0] hs_wdata = '0;

  mem_arbiter #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n), .rd(rd), .wd(wd), .addr(addr), .wdata(wdata),
    .seg_base(seg_base), .seg_limit(seg_limit), .rdata(rdata), .wait_o(wait_o), .segv(segv),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign mem_rdata = mem_addr ^ SCRAMBLE;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // memory model: acks ack_dly cycles after mem_req is first seen
  initial forever begin
    @(posedge clk); #1;
    mem_ack = 0;
    if (!mem_req) ack_cnt = 0;
    else if (ack_cnt >= ack_dly) begin
      mem_ack = 1;
      ack_cnt = 0;
      if (rand_ack) ack_dly = $urandom_range(0, 3);
    end else ack_cnt++;
  end

  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        if ((rd[i] | wd[i]) && !wait_o[i]) begin
          if (exp_q[i].size() == 0) chk("unexpected_done", 1, 0);
          else begin
            exp_t e;
            e = exp_q[i].pop_front();
            chk("rdata", rdata[i*DW +: DW], e.rdata);
            chk("segv", segv[i], e.segv);
            chk("mem_access", hs_seen, !e.segv);
            if (!e.segv && hs_seen) begin
              chk("mem_addr", hs_addr, e.phys);
              chk("mem_we", hs_we, e.we);
              if (e.we) chk("mem_wdata", hs_wdata, e.wdata);
            end
            chk("fairness", others[i] <= NCH - 1, 1);
            for (int j = 0; j < NCH; j++)
              if (j != i && (rd[j] | wd[j])) begin
                others[j]++;
                chk("loser_wait", wait_o[j], 1);
              end
            done_ch.push_back(i);
            done_cyc.push_back(cyc);
            hs_seen = 0;
          end
        end else chk("segv_idle", segv[i], 0);
      end
    end
    if (mem_req && mem_ack) begin
      hs_seen = 1;
      hs_addr = mem_addr;
      hs_we = mem_we;
      hs_wdata = mem_wdata;
    end
    if (mem_req) begin
      if (prev_req && {mem_addr, mem_we, mem_wdata} != prev_bus) stable = 0;
      req_cyc++;
    end
    prev_req = mem_req;
    prev_bus = {mem_addr, mem_we, mem_wdata};
  end

  task automatic drive(input int ch, input bit r, input bit w, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] l, input logic [DW-1:0] d);
    exp_t e;
    logic [AW:0] s;
    s = {1'b0, b} + {1'b0, a};
    e.segv = (r && w) || a[1:0] != 2'b00 || a >= l || s[AW];
    e.phys = s[AW-1:0];
    e.we = w;
    e.wdata = d;
    e.rdata = (e.segv || w) ? '0 : e.phys ^ SCRAMBLE;
    exp_q[ch].push_back(e);
    others[ch] = 0;
    rd[ch] = r;
    wd[ch] = w;
    addr[ch*AW +: AW] = a;
    seg_base[ch*AW +: AW] = b;
    seg_limit[ch*AW +: AW] = l;
    wdata[ch*DW +: DW] = d;
  endtask

  task automatic await_done(input int ch, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (wait_o[ch] && lat < 200);
    if (wait_o[ch]) chk("done_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic run(input string nm, input int ch, input bit r, input bit w, input logic [AW-1:0] a,
                     input logic [AW-1:0] b, input logic [AW-1:0] l, input logic [DW-1:0] d,
                     input int dly, input int exp_lat, input int exp_req);
    int lat;
    ack_dly = dly;
    req_cyc = 0;
    stable = 1;
    drive(ch, r, w, a, b, l, d);
    await_done(ch, lat);
    rd[ch] = 0;
    wd[ch] = 0;
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_memreq_cycles"}, req_cyc, exp_req);
    chk({nm, "_bus_stable"}, stable, 1);
  endtask

  task automatic random_req(input int ch);
    int m;
    logic [AW-1:0] a, b, l;
    m = $urandom_range(0, 9);
    b = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h7FFF_FFFC);
    l = $urandom_range(0, 'h200);
    a = $urandom_range(0, 'h27F) & ~32'h3;
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    drive(ch, m < 6 || m == 9, m >= 6, a, b, l, $urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_req", mem_req, 0);
    chk("reset_mem_we", mem_we, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_wdata", mem_wdata, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_segv", segv, 0);
    chk("reset_wait", wait_o, 0);
    @(posedge clk); #1;
    reset_n = 1;
    @(posedge clk); #1;
    run("read", 1, 1, 0, 'h10, 'h1000, 'h100, 0, 0, 3, 1);
    run("limit", 0, 1, 0, 'h100, 'h0, 'h100, 0, 0, 2, 0);
    run("align", 0, 1, 0, 'h2, 'h2000, 'h100, 0, 0, 2, 0);
    run("wrap", 1, 1, 0, 'h20, 'hFFFF_FFF0, 'h100, 0, 0, 2, 0);
    run("write", 1, 0, 1, 'h40, 'h3000, 'h100, 'hDEAD_BEEF, 4, 7, 5);
    run("rdwr", 0, 1, 1, 'h8, 'h0, 'h100, 0, 0, 2, 0);
    // contention: both channels reissue immediately after each done
    ack_dly = 0;
    done_ch.delete();
    done_cyc.delete();
    fork
      begin
        int l0;
        for (int k = 0; k < 4; k++) begin drive(0, 1, 0, 32'(k * 4), 'h100, 'h100, 0); await_done(0, l0); end
        rd[0] = 0;
      end
      begin
        int l1;
        for (int k = 0; k < 4; k++) begin drive(1, 1, 0, 32'(k * 8), 'h800, 'h100, 0); await_done(1, l1); end
        rd[1] = 0;
      end
    join
    chk("contention_count", done_ch.size(), 8);
    for (int k = 1; k < done_ch.size(); k++) begin
      chk("contention_alternate", done_ch[k] != done_ch[k-1], 1);
      chk("contention_spacing", done_cyc[k] - done_cyc[k-1], 3);
    end
    // reset while the memory access is outstanding
    ack_dly = 20;
    drive(1, 1, 0, 'h10, 'h1000, 'h100, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_req && n < 10);
    chk("reset_mid_reached_issue", mem_req, 1);
    mon_en = 0;
    #1 reset_n = 0;
    #1 chk("reset_mid_mem_req", mem_req, 0);
    chk("reset_mid_no_done", wait_o[1], 1);
    exp_q[1].delete();
    rd[1] = 0;
    @(posedge clk); #1;
    hs_seen = 0;
    reset_n = 1;
    mon_en = 1;
    ack_dly = 0;
    done_ch.delete();
    drive(0, 1, 0, 'h4, 'h500, 'h100, 0);
    drive(1, 1, 0, 'h8, 'h600, 'h100, 0);
    await_done(0, lat);
    rd[0] = 0;
    await_done(1, lat);
    rd[1] = 0;
    chk("post_reset_first", done_ch.size() > 0 ? done_ch[0] : -1, 0);
    // randomized traffic
    rand_ack = 1;
    fork
      begin
        int l0;
        for (int k = 0; k < 30; k++) begin
          random_req(0); await_done(0, l0); rd[0] = 0; wd[0] = 0;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
      begin
        int l1;
        for (int k = 0; k < 30; k++) begin
          random_req(1); await_done(1, l1); rd[1] = 0; wd[1] = 0;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
    join
    repeat (4) @(posedge clk);
    chk("scoreboard_empty0", exp_q[0].size(), 0);
    chk("scoreboard_empty1", exp_q[1].size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
